maxpool2x2_stream: RTL and testbench

Streaming 2×2, stride-2 max-pooling stage that consumes the raster-scan pixel stream of a convolution layer after its pipeline-alignment delay stage. It emits one pooled pixel per 2×2 block using a half-width line buffer of partial maxima. It has no backpressure, so it sustains one input pixel per cycle indefinitely. Its output feeds the next convolution layer's input stage, for example 28×28 C1 maps reduced to 14×14 S2 maps.

---
 rtl/maxpool2x2_stream.sv | 123 ++++++++++++
 tb/tb_maxpool2x2_stream.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: streaming 2x2 / stride-2 max pooling over a raster-scan
// pixel stream. A horizontal pair maximum is formed on every odd column; on even
// rows it is parked in a half-width line buffer, and on odd rows it is combined
// with the parked value to emit one pooled pixel. No backpressure; one pixel per
// cycle is sustained indefinitely, and gaps on valid_in simply hold all state.
module maxpool2x2_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         frame_done
);

  localparam int COL_W  = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W  = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam int HALF_W = IMG_WIDTH / 2;
  localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  // Odd or degenerate frame dimensions cannot be tiled by 2x2 blocks.
  generate
    if ((IMG_WIDTH % 2) != 0 || IMG_WIDTH < 2 ||
        (IMG_HEIGHT % 2) != 0 || IMG_HEIGHT < 2) begin : g_bad_params
      $error("maxpool2x2_stream: IMG_WIDTH and IMG_HEIGHT must be even and >= 2");
    end
  endgenerate

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  logic        [COL_W-1:0]      col_q, col_d;
  logic        [ROW_W-1:0]      row_q, row_d;
  logic signed [DATA_WIDTH-1:0] hmax_q, hmax_d;
  logic                         valid_q, valid_d;
  logic signed [DATA_WIDTH-1:0] data_q, data_d;
  logic                         done_q, done_d;

  // Line buffer is data-only: every entry is written on an even row before an
  // odd row reads it, so it needs no reset.
  logic signed [DATA_WIDTH-1:0] linebuf [HALF_W];

  logic                         last_col, last_row, col_odd, row_odd;
  logic        [IDX_W-1:0]      idx;
  logic signed [DATA_WIDTH-1:0] pair, result;

  // Position decode and the two max comparators (horizontal pair, vertical merge).
  always_comb begin
    last_col = (col_q == COL_W'(IMG_WIDTH - 1));
    last_row = (row_q == ROW_W'(IMG_HEIGHT - 1));
    col_odd  = col_q[0];
    row_odd  = row_q[0];
    idx      = IDX_W'(col_q >> 1);
    pair     = smax(hmax_q, data_in);
    result   = smax(linebuf[idx], pair);
  end

  // Next-state: raster counters, pair holding register and the output register.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    hmax_d  = hmax_q;
    valid_d = 1'b0;
    data_d  = data_q;
    done_d  = 1'b0;
    if (valid_in) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      if (!col_odd) begin
        hmax_d = data_in;
      end
      if (col_odd && row_odd) begin
        valid_d = 1'b1;
        data_d  = result;
        done_d  = last_col && last_row;
      end
    end
  end

  // ---- stage boundary: input pixel -> registered pooled output ----
  // State register with asynchronous reset; a reset mid-frame restarts at (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      hmax_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hmax_q  <= hmax_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Park the horizontal pair maximum of each even row for the odd row below it.
  always_ff @(posedge clk) begin
    if (valid_in && col_odd && !row_odd) begin
      linebuf[idx] <= pair;
    end
  end

  assign valid_out  = valid_q;
  assign data_out   = data_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Testbench for maxpool2x2_stream. Three instances (4x4/16b, 4x4/8b, 28x28/16b)
// are exercised one at a time; a frame-array reference model predicts every
// output cycle, and fixed result lists cover the documented scenarios.
module tb_maxpool2x2_stream;

  logic clk;
  logic reset;

  logic               v0, v1, v2;
  logic signed [15:0] d0, d2;
  logic signed [7:0]  d1;
  logic               vo0, vo1, vo2;
  logic signed [15:0] do0, do2;
  logic signed [7:0]  do1;
  logic               fd0, fd1, fd2;

  maxpool2x2_stream #(.DATA_WIDTH(16), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u0 (
    .clk(clk), .reset(reset), .valid_in(v0), .data_in(d0),
    .valid_out(vo0), .data_out(do0), .frame_done(fd0));

  maxpool2x2_stream #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u1 (
    .clk(clk), .reset(reset), .valid_in(v1), .data_in(d1),
    .valid_out(vo1), .data_out(do1), .frame_done(fd1));

  maxpool2x2_stream #(.DATA_WIDTH(16), .IMG_WIDTH(28), .IMG_HEIGHT(28)) u2 (
    .clk(clk), .reset(reset), .valid_in(v2), .data_in(d2),
    .valid_out(vo2), .data_out(do2), .frame_done(fd2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int sel;
  int obs_v, obs_d, obs_fd;

  always_comb begin
    obs_v  = 0;
    obs_d  = 0;
    obs_fd = 0;
    case (sel)
      0: begin obs_v = int'(vo0); obs_d = int'(do0); obs_fd = int'(fd0); end
      1: begin obs_v = int'(vo1); obs_d = int'(do1); obs_fd = int'(fd1); end
      default: begin obs_v = int'(vo2); obs_d = int'(do2); obs_fd = int'(fd2); end
    endcase
  end

  int nchk  = 0;
  int npass = 0;
  int nout  = 0;
  int nfd   = 0;
  int outq[$];

  // reference model state
  int img [0:27][0:27];
  int mr, mc;
  int last_out [0:2];

  function automatic int fdim(input int s);
    return (s == 2) ? 28 : 4;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    if (obs !== exp)
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    else
      npass++;
  endtask

  task automatic model_reset();
    mr = 0;
    mc = 0;
    for (int i = 0; i < 3; i++) last_out[i] = 0;
  endtask

  // One clock cycle: drive, let the edge happen, then compare against the model.
  task automatic cycle(input bit v, input int val);
    int ev, ex, efd, n;
    v0 = (sel == 0) && v; d0 = 16'(val);
    v1 = (sel == 1) && v; d1 = 8'(val);
    v2 = (sel == 2) && v; d2 = 16'(val);
    @(posedge clk);
    #1;
    n = fdim(sel);
    ev = 0; ex = 0; efd = 0;
    if (v) begin
      img[mr][mc] = val;
      if ((mr % 2 == 1) && (mc % 2 == 1)) begin
        ev  = 1;
        ex  = imax(imax(img[mr-1][mc-1], img[mr-1][mc]), imax(img[mr][mc-1], img[mr][mc]));
        efd = (mr == n - 1 && mc == n - 1) ? 1 : 0;
      end
      mc++;
      if (mc == n) begin
        mc = 0;
        mr = (mr == n - 1) ? 0 : mr + 1;
      end
    end
    chk("valid_out", obs_v, ev);
    chk("frame_done", obs_fd, efd);
    if (ev != 0) last_out[sel] = ex;
    chk("data_out", obs_d, last_out[sel]);
    if (obs_v != 0) begin
      outq.push_back(obs_d);
      nout++;
    end
    if (obs_fd != 0) nfd++;
  endtask

  // Reset asserted between clock edges; outputs must clear immediately.
  task automatic do_reset(input int ncyc);
    v0 = 0; v1 = 0; v2 = 0;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", obs_v, 0);
    chk("rst_data", obs_d, 0);
    chk("rst_done", obs_fd, 0);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      chk("rst_valid_hold", obs_v, 0);
      chk("rst_data_hold", obs_d, 0);
    end
    reset = 1'b0;
  endtask

  // kind 0: ramp base+i, kind 1: random signed 16-bit
  task automatic frame(input int kind, input int base, input bit gaps, input int npix);
    logic signed [15:0] r;
    for (int i = 0; i < npix; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) cycle(1'b0, 0);
      end
      if (kind == 0) begin
        cycle(1'b1, base + i);
      end else begin
        r = 16'($urandom);
        cycle(1'b1, int'(r));
      end
    end
  endtask

  task automatic clear_obs();
    outq.delete();
    nout = 0;
    nfd  = 0;
  endtask

  task automatic check_list(input string tag, input int exp[$]);
    chk({tag, "_count"}, outq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < outq.size(); i++)
      chk(tag, outq[i], exp[i]);
  endtask

  initial begin
    sel = 0;
    v0 = 0; v1 = 0; v2 = 0;
    d0 = 0; d1 = 0; d2 = 0;
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) img[r][c] = 0;
    @(negedge clk);
    do_reset(2);

    // 4x4 ramp 0..15, continuous
    clear_obs();
    frame(0, 0, 1'b0, 16);
    check_list("ramp", '{5, 7, 13, 15});
    chk("ramp_fd", nfd, 1);
    repeat (3) cycle(1'b0, 0);

    // same stream with random gaps
    clear_obs();
    frame(0, 0, 1'b1, 16);
    check_list("gaps", '{5, 7, 13, 15});
    chk("gaps_fd", nfd, 1);

    // two back-to-back frames
    clear_obs();
    frame(0, 0, 1'b0, 16);
    frame(0, 100, 1'b0, 16);
    check_list("b2b", '{5, 7, 13, 15, 105, 107, 113, 115});
    chk("b2b_fd", nfd, 2);

    // reset after 9 pixels, then a fresh frame
    clear_obs();
    frame(0, 200, 1'b0, 9);
    do_reset(3);
    clear_obs();
    cycle(1'b0, 0);
    frame(0, 50, 1'b0, 16);
    check_list("post_rst", '{55, 57, 63, 65});
    chk("post_rst_fd", nfd, 1);

    // 8-bit signed, all negative
    sel = 1;
    clear_obs();
    frame(0, -16, 1'b0, 16);
    check_list("neg", '{-11, -9, -3, -1});
    chk("neg_fd", nfd, 1);

    // 28x28 random signed data, one continuous frame then one with gaps
    sel = 2;
    clear_obs();
    frame(1, 0, 1'b0, 784);
    frame(1, 0, 1'b1, 784);
    repeat (2) cycle(1'b0, 0);
    chk("big_outputs", nout, 392);
    chk("big_fd", nfd, 2);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
